// File: rtl/fpu_iter_div_sqrt.sv
// Radix-2 restoring mantissa divider / square-root engine, one result bit per cycle.
// Produces the pre-normalised quotient or root plus the unrounded biased exponent and sign.
//   state | meaning
//   IDLE  | waiting for a start
//   BUSY  | iterating, one result bit per edge
//   DONE  | result valid for one cycle, a new start is accepted here
module fpu_iter_div_sqrt #(
    parameter int C_MANT    = 23,
    parameter int C_EXP     = 8,
    parameter int C_PRENORM = C_MANT + 1,
    parameter int C_BIAS    = 2**(C_EXP-1) - 1
) (
    input  logic                 Clk_CI,
    input  logic                 Rst_RBI,
    input  logic                 Start_SI,
    input  logic                 Kill_SI,
    input  logic                 Div_enable_SI,
    input  logic                 Special_SI,
    input  logic [C_PRENORM-1:0] Mant_a_DI,
    input  logic [C_PRENORM-1:0] Mant_b_DI,
    input  logic [C_EXP+1:0]     Exp_a_DI,
    input  logic [C_EXP+1:0]     Exp_b_DI,
    input  logic                 Sign_a_DI,
    input  logic                 Sign_b_DI,
    output logic                 Ready_SO,
    output logic                 Done_SO,
    output logic [C_PRENORM-1:0] Mant_DO,
    output logic [C_EXP+1:0]     Exp_DO,
    output logic                 Sign_DO
);

    localparam int C_REM = C_PRENORM + 2;
    localparam int C_TW  = C_REM + 1;
    localparam int C_CNT = $clog2(C_PRENORM + 1);
    localparam logic [C_EXP+1:0] BIAS_W   = (C_EXP+2)'(C_BIAS);
    localparam logic [C_CNT-1:0] LAST_CNT = C_CNT'(C_PRENORM - 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t                   state_q;
    logic [C_CNT-1:0]         cnt_q;
    logic                     div_q;
    logic [C_REM-1:0]         rem_q;
    logic [C_PRENORM-1:0]     divisor_q;
    logic [2*C_PRENORM-1:0]   rad_q;
    logic [C_PRENORM-1:0]     mant_q;
    logic [C_EXP+1:0]         exp_q;
    logic                     sign_q;
    logic                     ready_q;
    logic                     done_q;

    logic [C_EXP+1:0]         exp_e;
    logic [C_EXP+1:0]         exp_start_d;
    logic                     sign_start_d;
    logic [2*C_PRENORM-1:0]   rad_init_d;
    logic [C_REM-1:0]         rem_init_d;
    logic [C_TW-1:0]          trial_div;
    logic [C_TW-1:0]          trial_sqrt;
    logic [C_REM-1:0]         rem4;
    logic [C_REM-1:0]         rem_sel;
    logic                     bit_d;
    logic [C_REM-1:0]         rem_d;
    logic [C_PRENORM-1:0]     mant_d;

    always_comb begin
        exp_e = Exp_a_DI - BIAS_W;
        if (Div_enable_SI) begin
            exp_start_d  = Exp_a_DI - Exp_b_DI + BIAS_W;
            sign_start_d = Sign_a_DI ^ Sign_b_DI;
        end else begin
            exp_start_d  = {exp_e[C_EXP+1], exp_e[C_EXP+1:1]} + BIAS_W;
            sign_start_d = Sign_a_DI;
        end
        // An odd unbiased exponent is absorbed by doubling the radicand
        rad_init_d = exp_e[0] ? {Mant_a_DI, {C_PRENORM{1'b0}}}
                              : {1'b0, Mant_a_DI, {(C_PRENORM-1){1'b0}}};
        rem_init_d = Div_enable_SI ? {2'b00, Mant_a_DI} : '0;

        trial_div  = {1'b0, rem_q} - {3'b000, divisor_q};
        // The sqrt remainder stays below 2*root, so its top two bits are always clear here
        rem4       = {rem_q[C_REM-3:0], rad_q[2*C_PRENORM-1 -: 2]};
        trial_sqrt = {1'b0, rem4} - {1'b0, mant_q, 2'b01};

        rem_sel = rem_q;
        if (div_q) begin
            bit_d   = ~trial_div[C_TW-1];
            rem_sel = bit_d ? trial_div[C_REM-1:0] : rem_q;
            rem_d   = rem_sel << 1;
        end else begin
            bit_d = ~trial_sqrt[C_TW-1];
            rem_d = bit_d ? trial_sqrt[C_REM-1:0] : rem4;
        end
        mant_d = {mant_q[C_PRENORM-2:0], bit_d};
    end

    always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
        if (!Rst_RBI) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            div_q     <= 1'b0;
            rem_q     <= '0;
            divisor_q <= '0;
            rad_q     <= '0;
            mant_q    <= '0;
            exp_q     <= '0;
            sign_q    <= 1'b0;
            ready_q   <= 1'b1;
            done_q    <= 1'b0;
        end else if (Kill_SI) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ready_q <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    done_q <= 1'b0;
                    if (Start_SI) begin
                        div_q     <= Div_enable_SI;
                        rem_q     <= rem_init_d;
                        divisor_q <= Mant_b_DI;
                        rad_q     <= rad_init_d;
                        mant_q    <= '0;
                        cnt_q     <= '0;
                        sign_q    <= sign_start_d;
                        if (Special_SI) begin
                            exp_q   <= '0;
                            state_q <= DONE;
                            done_q  <= 1'b1;
                            ready_q <= 1'b1;
                        end else begin
                            exp_q   <= exp_start_d;
                            state_q <= BUSY;
                            ready_q <= 1'b0;
                        end
                    end else begin
                        state_q <= IDLE;
                        ready_q <= 1'b1;
                    end
                end
                BUSY: begin
                    rem_q  <= rem_d;
                    rad_q  <= rad_q << 2;
                    mant_q <= mant_d;
                    cnt_q  <= cnt_q + 1'b1;
                    if (cnt_q == LAST_CNT) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                        ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    ready_q <= 1'b1;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign Ready_SO = ready_q;
    assign Done_SO  = done_q;
    assign Mant_DO  = mant_q;
    assign Exp_DO   = exp_q;
    assign Sign_DO  = sign_q;

endmodule

// File: tb/tb_fpu_iter_div_sqrt.sv
// Scoreboard bench for fpu_iter_div_sqrt: directed cases plus random div/sqrt traffic
// checked against an arithmetic reference (integer division, real-valued square root).
module tb_fpu_iter_div_sqrt;

    localparam int P    = 24;
    localparam int EW   = 10;
    localparam int BIAS = 127;

    logic          clk;
    logic          rst_n;
    logic          start, kill, div_en, special;
    logic [P-1:0]  mant_a, mant_b;
    logic [EW-1:0] exp_a, exp_b;
    logic          sign_a, sign_b;
    logic          ready, done;
    logic [P-1:0]  mant_o;
    logic [EW-1:0] exp_o;
    logic          sign_o;

    typedef struct {
        logic [P-1:0]  mant;
        logic [EW-1:0] exp;
        logic          sign;
        longint        due;
    } exp_t;

    exp_t   sb[$];
    longint cycle = 0;
    int     n_checks = 0;
    int     n_fail = 0;

    fpu_iter_div_sqrt dut (
        .Clk_CI(clk), .Rst_RBI(rst_n), .Start_SI(start), .Kill_SI(kill),
        .Div_enable_SI(div_en), .Special_SI(special),
        .Mant_a_DI(mant_a), .Mant_b_DI(mant_b), .Exp_a_DI(exp_a), .Exp_b_DI(exp_b),
        .Sign_a_DI(sign_a), .Sign_b_DI(sign_b),
        .Ready_SO(ready), .Done_SO(done), .Mant_DO(mant_o), .Exp_DO(exp_o), .Sign_DO(sign_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cycle++;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cycle);
        end
    endtask

    function automatic logic [P-1:0] ref_div(input logic [P-1:0] a, input logic [P-1:0] b);
        longint q;
        q = (longint'(a) << (P - 1)) / longint'(b);
        return P'(q);
    endfunction

    function automatic logic [P-1:0] ref_sqrt(input logic [P-1:0] a, input logic [EW-1:0] ea);
        int     e;
        longint rad, r;
        e   = int'($signed(ea)) - BIAS;
        rad = longint'(a) << (((e % 2) != 0) ? P : P - 1);
        r   = longint'($sqrt(real'(rad)));
        for (int i = 0; i < 4 && r * r > rad; i++) r--;
        for (int i = 0; i < 4 && (r + 1) * (r + 1) <= rad; i++) r++;
        return P'(r);
    endfunction

    function automatic exp_t ref_model(input bit d, input bit sp, input logic [P-1:0] a,
                                       input logic [P-1:0] b, input logic [EW-1:0] ea,
                                       input logic [EW-1:0] eb, input bit sa, input bit sbit);
        exp_t r;
        int   e;
        r.sign = d ? (sa ^ sbit) : sa;
        r.due  = 0;
        if (sp) begin
            r.mant = '0;
            r.exp  = '0;
        end else if (d) begin
            r.mant = ref_div(a, b);
            r.exp  = EW'(int'($signed(ea)) - int'($signed(eb)) + BIAS);
        end else begin
            e      = int'($signed(ea)) - BIAS;
            r.mant = ref_sqrt(a, ea);
            r.exp  = EW'(int'($floor(real'(e) / 2.0)) + BIAS);
        end
        return r;
    endfunction

    // Waits for Ready, issues one start, returns the accepting edge's cycle number
    task automatic issue(input bit d, input bit sp, input logic [P-1:0] a, input logic [P-1:0] b,
                         input logic [EW-1:0] ea, input logic [EW-1:0] eb, input bit sa,
                         input bit sbit, input bit push, output longint acc);
        int   guard;
        exp_t r;
        guard = 0;
        acc   = -1;
        @(negedge clk);
        while (!ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (!ready) begin
            check("ready_timeout", 64'(ready), 64'd1);
            return;
        end
        div_en = d; special = sp; mant_a = a; mant_b = b;
        exp_a = ea; exp_b = eb; sign_a = sa; sign_b = sbit;
        start = 1'b1;
        @(posedge clk);
        #1;
        start   = 1'b0;
        special = 1'b0;
        acc     = cycle;
        if (push) begin
            r     = ref_model(d, sp, a, b, ea, eb, sa, sbit);
            r.due = acc + (sp ? 0 : P);
            sb.push_back(r);
        end
        check("ready_after_start", 64'(ready), sp ? 64'd1 : 64'd0);
    endtask

    always @(negedge clk) begin
        exp_t ent;
        if (rst_n) begin
            if (done) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_done: Done_SO=1 at cycle %0d, expected no result", cycle);
                end else begin
                    ent = sb.pop_front();
                    check("mant", 64'(mant_o), 64'(ent.mant));
                    check("exp", 64'(exp_o), 64'(ent.exp));
                    check("sign", 64'(sign_o), 64'(ent.sign));
                    check("done_cycle", 64'(cycle), 64'(ent.due));
                end
            end else if (sb.size() > 0 && cycle > sb[0].due) begin
                n_checks++;
                n_fail++;
                $display("FAIL missing_done: no Done_SO by cycle %0d, expected at %0d", cycle, sb[0].due);
                void'(sb.pop_front());
            end
        end
    end

    initial begin
        longint acc, acc2, due1;
        bit d, sp;
        logic [P-1:0] a, b;
        logic [EW-1:0] ea, eb;
        rst_n = 1'b0; start = 1'b0; kill = 1'b0; div_en = 1'b0; special = 1'b0;
        mant_a = '0; mant_b = '0; exp_a = '0; exp_b = '0; sign_a = 1'b0; sign_b = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_ready", 64'(ready), 64'd1);
        check("rst_done", 64'(done), 64'd0);
        check("rst_mant", 64'(mant_o), 64'd0);
        check("rst_exp", 64'(exp_o), 64'd0);
        rst_n = 1'b1;

        // Directed: 1.5/1.0, 1.0/1.5 with sign, sqrt 4.0, sqrt 2.0
        issue(1, 0, 24'hC00000, 24'h800000, 10'd127, 10'd127, 0, 0, 1, acc);
        issue(1, 0, 24'h800000, 24'hC00000, 10'd127, 10'd127, 1, 0, 1, acc);
        issue(0, 0, 24'h800000, 24'h0, 10'd129, 10'd0, 0, 0, 1, acc);
        issue(0, 0, 24'h800000, 24'h0, 10'd128, 10'd0, 0, 0, 1, acc);
        check("dir_div_ref", 64'(ref_div(24'hC00000, 24'h800000)), 64'hC00000);
        check("dir_sqrt2_ref", 64'(ref_sqrt(24'h800000, 10'd128)), 64'hB504F3);

        // Kill at iteration 10, then a normal divide must still be correct
        issue(1, 0, 24'hC00000, 24'h800000, 10'd127, 10'd127, 0, 0, 0, acc);
        repeat (9) @(posedge clk);
        @(negedge clk);
        kill  = 1'b1;
        start = 1'b1;
        @(posedge clk);
        #1;
        kill  = 1'b0;
        start = 1'b0;
        check("kill_ready", 64'(ready), 64'd1);
        check("kill_done", 64'(done), 64'd0);
        repeat (30) @(negedge clk);
        issue(1, 0, 24'hC00000, 24'h800000, 10'd127, 10'd127, 0, 0, 1, acc);

        // Start pulsed while busy must not disturb the running divide
        issue(1, 0, 24'h800000, 24'hC00000, 10'd130, 10'd120, 0, 1, 1, acc);
        repeat (5) @(negedge clk);
        div_en = 1'b0; mant_a = 24'hFFFFFF; exp_a = 10'd3; sign_a = 1'b1;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("busy_ready", 64'(ready), 64'd0);

        // Back-to-back: second start held in the DONE cycle
        issue(0, 0, 24'hA00000, 24'h0, 10'd140, 10'd0, 1, 0, 1, acc);
        due1 = acc + P;
        issue(1, 0, 24'hF00000, 24'h900000, 10'd100, 10'd110, 1, 1, 1, acc2);
        check("b2b_accept", 64'(acc2), 64'(due1 + 1));

        // Special operand: immediate done with zero mantissa/exponent
        issue(1, 1, 24'hC00000, 24'h800000, 10'd127, 10'd127, 1, 0, 1, acc);
        issue(0, 1, 24'hC00000, 24'h800000, 10'd127, 10'd127, 1, 0, 1, acc);

        for (int i = 0; i < 40; i++) begin
            d  = 1'($urandom_range(0, 1));
            sp = ($urandom_range(0, 9) == 0);
            a  = 24'h800000 | P'($urandom);
            b  = 24'h800000 | P'($urandom);
            ea = EW'(int'($urandom_range(0, 400)) - 50);
            eb = EW'(int'($urandom_range(0, 400)) - 50);
            issue(d, sp, a, b, ea, eb, 1'($urandom), 1'($urandom), 1, acc);
        end

        for (int i = 0; i < 100 && sb.size() > 0; i++) @(negedge clk);

        // Asynchronous reset in the middle of an operation
        issue(1, 0, 24'hC00000, 24'h800000, 10'd127, 10'd127, 1, 1, 0, acc);
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("arst_ready", 64'(ready), 64'd1);
        check("arst_done", 64'(done), 64'd0);
        check("arst_mant", 64'(mant_o), 64'd0);
        check("arst_exp", 64'(exp_o), 64'd0);
        check("arst_sign", 64'(sign_o), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        issue(1, 0, 24'hC00000, 24'h800000, 10'd127, 10'd127, 0, 0, 1, acc);

        for (int i = 0; i < 100 && sb.size() > 0; i++) @(negedge clk);
        if (sb.size() > 0) check("drain", 64'(sb.size()), 64'd0);
        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
